// File: rtl/reg_mem_arbiter.sv
// -----------------------------------------------------------------------------
// reg_mem_arbiter
//
// Purpose:
//   Shares one single-port register-entry memory between the software register
//   path (sw_*) and the hardware datapath requester (hw_*). After reset the
//   block walks every entry and writes RST_VALUE (optional). It then
//   arbitrates round-robin between the two ports. Accepted accesses go to the
//   memory in the cycle they are accepted. A response is routed back to the
//   issuing port exactly RD_LATENCY cycles later.
//
// Parameters:
//   F_WIDTH    - entry width in bits
//   ADDR_WIDTH - memory address width (DEPTH = 1 << ADDR_WIDTH)
//   RD_LATENCY - cycles from a read strobe to valid mem_rd_data (1..4)
//   RST_VALUE  - value written to every entry during init
//   INIT_EN    - 1: clear memory after reset, 0: skip the clear walk
//
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   sw_req_* / hw_req_*   - request channels (vld/rdy handshake, wr, addr, data)
//   sw_rsp_* / hw_rsp_*   - response pulse and read data (0 for writes)
//   mem_*                 - single-port memory interface
//   init_done             - high once the init walk has finished
// -----------------------------------------------------------------------------
module reg_mem_arbiter #(
    parameter int                  F_WIDTH    = 36,
    parameter int                  ADDR_WIDTH = 7,
    parameter int                  RD_LATENCY = 1,
    parameter logic [F_WIDTH-1:0]  RST_VALUE  = '0,
    parameter bit                  INIT_EN    = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   sw_req_vld,
    input  logic                   sw_req_wr,
    input  logic [ADDR_WIDTH-1:0]  sw_req_addr,
    input  logic [F_WIDTH-1:0]     sw_req_wr_data,
    output logic                   sw_req_rdy,
    output logic                   sw_rsp_vld,
    output logic [F_WIDTH-1:0]     sw_rsp_rd_data,

    input  logic                   hw_req_vld,
    input  logic                   hw_req_wr,
    input  logic [ADDR_WIDTH-1:0]  hw_req_addr,
    input  logic [F_WIDTH-1:0]     hw_req_wr_data,
    output logic                   hw_req_rdy,
    output logic                   hw_rsp_vld,
    output logic [F_WIDTH-1:0]     hw_rsp_rd_data,

    output logic                   mem_en,
    output logic                   mem_wr,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [F_WIDTH-1:0]     mem_wr_data,
    input  logic [F_WIDTH-1:0]     mem_rd_data,

    output logic                   init_done
);

    typedef enum logic {
        ST_INIT   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    typedef enum logic {
        PORT_SW = 1'b0,
        PORT_HW = 1'b1
    } port_t;

    // One slot of the response pipeline: which port issued the access and
    // whether it was a read (read data is taken from memory) or a write.
    typedef struct packed {
        logic  vld;
        port_t port;
        logic  is_rd;
    } rsp_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic [ADDR_WIDTH-1:0] w_init_cnt_nxt;
    port_t                 r_last_gnt;
    port_t                 w_last_gnt_nxt;
    rsp_t                  r_pipe [RD_LATENCY];
    rsp_t                  w_rsp_new;
    rsp_t                  w_rsp_out;
    logic                  w_gnt_sw;
    logic                  w_gnt_hw;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_last_gnt <= PORT_HW;   // sw wins the first tie after reset
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
            r_last_gnt <= w_last_gnt_nxt;
        end
    end

    // NOTE: the response pipeline is reset so that a reset drops every access
    // in flight; the memory array itself is never reset, the init walk
    // clears it instead.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_rsp_new;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next state, arbitration and memory strobes
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_last_gnt_nxt = r_last_gnt;
        w_gnt_sw       = 1'b0;
        w_gnt_hw       = 1'b0;
        w_rsp_new      = '0;
        mem_en         = 1'b0;
        mem_wr         = 1'b0;
        mem_addr       = '0;
        mem_wr_data    = '0;

        // Everything is held quiet while reset is asserted, so a request
        // presented during the reset cycle is never accepted.
        if (rst_n) begin
            case (r_state)
                ST_INIT: begin
                    if (INIT_EN) begin
                        mem_en         = 1'b1;
                        mem_wr         = 1'b1;
                        mem_addr       = r_init_cnt;
                        mem_wr_data    = RST_VALUE;
                        w_init_cnt_nxt = r_init_cnt + 1'b1;
                        // The last address is all ones; leave after writing it.
                        if (&r_init_cnt) begin
                            w_state_nxt = ST_ACTIVE;
                        end
                    end else begin
                        w_state_nxt = ST_ACTIVE;
                    end
                end

                ST_ACTIVE: begin
                    // On a tie the port that was not granted last goes first.
                    w_gnt_sw = sw_req_vld && (!hw_req_vld || (r_last_gnt == PORT_HW));
                    w_gnt_hw = hw_req_vld && !w_gnt_sw;

                    if (w_gnt_sw) begin
                        mem_en         = 1'b1;
                        mem_wr         = sw_req_wr;
                        mem_addr       = sw_req_addr;
                        mem_wr_data    = sw_req_wr_data;
                        w_last_gnt_nxt = PORT_SW;
                        w_rsp_new      = '{vld: 1'b1, port: PORT_SW, is_rd: !sw_req_wr};
                    end else if (w_gnt_hw) begin
                        mem_en         = 1'b1;
                        mem_wr         = hw_req_wr;
                        mem_addr       = hw_req_addr;
                        mem_wr_data    = hw_req_wr_data;
                        w_last_gnt_nxt = PORT_HW;
                        w_rsp_new      = '{vld: 1'b1, port: PORT_HW, is_rd: !hw_req_wr};
                    end
                end

                default: begin
                    w_state_nxt = ST_INIT;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign sw_req_rdy = w_gnt_sw;
    assign hw_req_rdy = w_gnt_hw;

    // The last pipeline stage lines up with mem_rd_data of the access it tracks.
    assign w_rsp_out = r_pipe[RD_LATENCY-1];

    assign sw_rsp_vld = rst_n && w_rsp_out.vld && (w_rsp_out.port == PORT_SW);
    assign hw_rsp_vld = rst_n && w_rsp_out.vld && (w_rsp_out.port == PORT_HW);

    // Read data is forwarded only for read responses; otherwise it is zero.
    assign sw_rsp_rd_data = (sw_rsp_vld && w_rsp_out.is_rd) ? mem_rd_data : '0;
    assign hw_rsp_rd_data = (hw_rsp_vld && w_rsp_out.is_rd) ? mem_rd_data : '0;

    assign init_done = rst_n && (r_state == ST_ACTIVE);

endmodule
